// File: rtl/and4_mon_pkg.sv
// Shared types and limits for the AND4 event monitor: FSM state encoding,
// run-counter width and the legal parameter ranges.
package and4_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2
  } mon_state_e;

  localparam int RUN_W = 4;

  localparam int DEB_LEN_MIN = 1;
  localparam int DEB_LEN_MAX = 15;
  localparam int CNT_W_MIN   = 2;
  localparam int CNT_W_MAX   = 16;

  function automatic bit params_legal(input int deb_len, input int cnt_w);
    return (deb_len >= DEB_LEN_MIN) && (deb_len <= DEB_LEN_MAX) &&
           (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
  endfunction

endpackage

// File: rtl/and4_event_monitor_if.sv
// Event-count handshake between the monitor (master) and its consumer (slave).
interface and4_event_monitor_if #(
  parameter int CNT_W = 8
);

  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_count;

  modport master (
    output evt_valid,
    output evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_count,
    output evt_ready
  );

endinterface

// File: rtl/and4_capture.sv
// Registers the four AND operands plus a sample-valid flag and exposes the
// AND of the captured operands; reusable in front of other gate-level stages.
module and4_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic v_q,
  output logic f_q
);

  logic [3:0] ops_q;
  logic [3:0] ops_d;
  logic       valid_q;
  logic       valid_d;

  always_comb begin
    ops_d   = ops_q;
    valid_d = in_valid;
    if (in_valid) begin
      ops_d = {a, b, c, d};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ops_q   <= ops_d;
      valid_q <= valid_d;
    end
  end

  assign v_q = valid_q;
  assign f_q = &ops_q;

endmodule

// File: rtl/and4_event_monitor.sv
// Debounces the registered AND result, counts qualified assertion events
// (saturating, with sticky overflow) and offers the count over valid/ready.
module and4_event_monitor
  import and4_mon_pkg::*;
#(
  parameter int DEB_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f_q,
  output logic det,
  output logic overflow,
  and4_event_monitor_if.master evt
);

  if (!params_legal(DEB_LEN, CNT_W)) begin : g_param_check
    $error("and4_event_monitor: DEB_LEN or CNT_W out of range");
  end

  localparam logic [RUN_W-1:0] DEB_LEN_C = RUN_W'(DEB_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic v_q;

  mon_state_e       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc;
  logic             det_q, det_d;
  logic             evt_fire;

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  and4_capture u_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .v_q      (v_q),
    .f_q      (f_q)
  );

  assign run_inc = run_q + RUN_W'(1);

  // Only captured samples move the debouncer; gaps (v_q=0) freeze it.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    evt_fire = 1'b0;
    if (v_q) begin
      unique case (state_q)
        IDLE: begin
          if (f_q) begin
            run_d = RUN_W'(1);
            if (DEB_LEN == 1) begin
              state_d  = ACTIVE;
              evt_fire = 1'b1;
            end else begin
              state_d = QUAL;
            end
          end
        end
        QUAL: begin
          if (f_q) begin
            run_d = run_inc;
            if (run_inc == DEB_LEN_C) begin
              state_d  = ACTIVE;
              evt_fire = 1'b1;
            end
          end else begin
            run_d   = '0;
            state_d = IDLE;
          end
        end
        ACTIVE: begin
          if (!f_q) begin
            run_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          run_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    det_d = (state_d == ACTIVE);
  end

  // A fresh event wins over acceptance so the newest count is never dropped.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (valid_q && evt.evt_ready) begin
      valid_d = 1'b0;
    end
    if (evt_fire) begin
      valid_d = 1'b1;
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      det_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      det_q   <= det_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign det           = det_q;
  assign overflow      = ovf_q;
  assign evt.evt_valid = valid_q;
  assign evt.evt_count = cnt_q;

endmodule

// File: doc/and4_event_monitor.md
Name: and4_event_monitor

Overview:
- Sequential stage directly downstream of the four-input mixed-logic AND.
- Registers the four AND operands and forms the registered AND result.
- Debounces that result with an FSM, then counts qualified assertion events.
- Hands each event count to a consumer over a valid/ready handshake. This is the first clocked consumer of the gate-level AND outputs.

Parameters:
- DEB_LEN, 3, number of consecutive valid samples with AND=1 needed to declare an event (legal range 1..15).
- CNT_W, 8, width of the event counter (legal range 2..16).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  a/b/c/d carry a sample this cycle.
- a  in  1  AND operand 0.
- b  in  1  AND operand 1.
- c  in  1  AND operand 2.
- d  in  1  AND operand 3.
- f_q  out  1  registered AND of the last captured sample.
- det  out  1  debounced level: high while the input is in the qualified-asserted state.
- evt_valid  out  1  event count is available on evt_count.
- evt_ready  in  1  consumer accepts evt_count when it is high together with evt_valid.
- evt_count  out  CNT_W  total qualified events since reset, saturating.
- overflow  out  1  sticky flag; set when an event occurs while evt_count is already all-ones.

Behaviour:
- Reset: rst_n low at a rising edge clears all state, regardless of any operation in progress. The capture register, v_q, f_q, det, evt_valid, evt_count, overflow and the run counter all go to 0, and the FSM goes to IDLE.
- Capture stage:
  - On an edge with in_valid=1, {a,b,c,d} are loaded into the capture register and v_q is set to 1.
  - On an edge with in_valid=0, the capture register holds and v_q is set to 0.
  - f_q = a_q&b_q&c_q&d_q, so f_q is visible 1 cycle after the sample.
- The FSM advances only on edges where v_q=1. When v_q=0, all FSM state, the run counter and det hold.
- FSM states:
  - IDLE: if f_q=1, run=1; go to ACTIVE when DEB_LEN==1, otherwise to QUAL. If f_q=0, stay in IDLE.
  - QUAL: if f_q=1, run increments; when run reaches DEB_LEN, go to ACTIVE. If f_q=0, run=0 and go to IDLE.
  - ACTIVE: det=1 as a registered output. Stay while f_q=1. On f_q=0, go to IDLE and clear run.
- Event generation: the edge that enters ACTIVE is the event edge.
  - If evt_count < 2^CNT_W-1, evt_count increments.
  - If evt_count is already all-ones, evt_count holds and overflow is set to 1. overflow stays set until reset.
  - evt_valid is set to 1 on every event edge.
- Latency: det and evt_valid rise 2 cycles after the DEB_LEN-th consecutive qualifying sample is presented on the inputs.
- Handshake:
  - When evt_valid=1 and evt_ready=1 and there is no event on that edge, evt_valid clears.
  - When evt_valid=1 and evt_ready=0, evt_valid and evt_count hold, except when a new event occurs.
  - A new event while an earlier count is still pending updates evt_count in place; evt_valid stays 1. Only the latest count is observed and no event is lost from the count.
  - Acceptance on the same edge as a new event leaves evt_valid=1 with the new count.
- Gaps: in_valid low in the middle of a run does not break the run. Only a valid sample with AND=0 breaks it.
- Each ACTIVE period produces exactly one event, however long it lasts.

Decomposition:
- Shared package and4_mon_pkg holds:
  - the FSM state enum {IDLE, QUAL, ACTIVE} as a 2-bit encoding;
  - the run-counter width constant (4 bits);
  - the DEB_LEN/CNT_W legality limits.
- One natural sub-module, and4_capture: the input capture register, v_q and the f_q AND. It is reusable ahead of other gate-level stages.
- The FSM, event counter and handshake stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with a=b=c=d=1 and in_valid=1 -> f_q=0, det=0, evt_valid=0, evt_count=0, overflow=0; release -> f_q=1 on the next cycle.
- Debounce (DEB_LEN=3): present valid samples 1111,1111,0111,1111,1111,1111 -> no event after the first two; det rises 2 cycles after the final 1111; evt_count=1, evt_valid=1.
- Gap tolerance: present 1111, in_valid=0 for 4 cycles, then 1111,1111 -> exactly one event; evt_count=1.
- Backpressure: evt_ready=0 for 3 events -> evt_valid stays 1 with evt_count showing 1,2,3 in turn; raise evt_ready for 1 cycle -> evt_valid=0 the following cycle.
- Saturation (CNT_W=2): generate 5 events -> evt_count stops at 3; overflow=1 after the 4th event and stays 1.
- Reset mid-run: in state QUAL with run=2, assert rst_n=0 for one edge, then present 1111 twice -> no event; a third 1111 is needed.
